// File: rtl/seq_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider_if
// Purpose  : start/busy/done handshake and operand/result bus for seq_divider.
// Revision : 1.0
// ============================================================================
interface seq_divider_if #(
    parameter int W = 12
);
    logic             start;
    logic [2*W-1:0]   dividend;
    logic [W-1:0]     divisor;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   quotient;
    logic [W-1:0]     remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Purpose  : Sequential restoring divider, 2W-bit / W-bit, one quotient bit per clock.
// Revision : 1.0
// ============================================================================
module seq_divider #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);

    localparam int                 c_CNT_W = $clog2(2 * W);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(2 * W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    // r_dvd shifts dividend bits out of the top while quotient bits enter at the bottom.
    logic [2*W-1:0]     r_dvd;
    logic [W-1:0]       r_dvs;
    logic [W-1:0]       r_rem;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2*W-1:0]     r_quotient;
    logic [W-1:0]       r_remainder;
    logic               r_div_by_zero;

    logic               w_accept;
    logic               w_zero_div;
    logic               w_last;
    logic [W:0]         w_t;
    logic [W:0]         w_diff;
    logic               w_ge;
    logic [W-1:0]       w_rem_next;
    logic [2*W-1:0]     w_dvd_next;

    assign w_accept   = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_zero_div = (bus.divisor == '0);
    assign w_last     = (r_cnt == c_LAST);

    // The running remainder stays below the divisor, so W bits hold it; the
    // trial subtract is W+1 bits and its top bit is the borrow (t < divisor).
    assign w_t        = {r_rem, r_dvd[2*W-1]};
    assign w_diff     = w_t - {1'b0, r_dvs};
    assign w_ge       = ~w_diff[W];
    assign w_rem_next = w_ge ? w_diff[W-1:0] : w_t[W-1:0];
    assign w_dvd_next = {r_dvd[2*W-2:0], w_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_state_next = w_zero_div ? S_DONE : S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvd         <= '0;
            r_dvs         <= '0;
            r_rem         <= '0;
            r_cnt         <= '0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else if (w_accept) begin
            if (w_zero_div) begin
                r_quotient    <= '1;
                r_remainder   <= bus.dividend[W-1:0];
                r_div_by_zero <= 1'b1;
            end else begin
                r_dvd <= bus.dividend;
                r_dvs <= bus.divisor;
                r_rem <= '0;
                r_cnt <= '0;
            end
        end else if (r_state == S_RUN) begin
            r_dvd <= w_dvd_next;
            r_rem <= w_rem_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_quotient    <= w_dvd_next;
                r_remainder   <= w_rem_next;
                r_div_by_zero <= 1'b0;
            end
        end
    end

    assign bus.busy        = (r_state == S_RUN);
    assign bus.done        = (r_state == S_DONE);
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_divider
// Purpose  : Directed and random self-checking bench for seq_divider (W=12).
// Revision : 1.0
// ============================================================================
module tb_seq_divider;

    localparam int W = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    seq_divider_if #(.W(W)) bus ();

    seq_divider #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Launch one division; report edges from E0 to done, busy cycles seen, and done one cycle later.
    task automatic run_div(input logic [23:0] a, input logic [11:0] b,
                           output int lat, output int bcnt, output logic done_after);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat  = 0;
        bcnt = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        @(posedge clk);
        #1 done_after = bus.done;
    endtask

    task automatic test_reset();
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b dbz=%b q=%h r=%h expected all 0",
                     bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_basic();
        int lat, bcnt;
        logic da;
        run_div(24'd1000, 12'd7, lat, bcnt, da);
        checks++;
        if (bus.quotient !== 24'd142 || bus.remainder !== 12'd6 || bus.div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL basic_result got q=%0d r=%0d dbz=%b expected 142 6 0",
                     bus.quotient, bus.remainder, bus.div_by_zero);
        end
        checks++;
        if (lat !== 24) begin
            failures++;
            $display("FAIL basic_latency got %0d expected 24", lat);
        end
        checks++;
        if (bcnt !== 24) begin
            failures++;
            $display("FAIL basic_busy_cycles got %0d expected 24", bcnt);
        end
        checks++;
        if (da !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_width got done=%b next cycle expected 0", da);
        end
    endtask

    task automatic test_patterns();
        logic [23:0] va [3] = '{24'hFFFFFF, 24'hFFFFFF, 24'd5};
        logic [11:0] vb [3] = '{12'hFFF, 12'd1, 12'd9};
        logic [23:0] vq [3] = '{24'h001001, 24'hFFFFFF, 24'd0};
        logic [11:0] vr [3] = '{12'd0, 12'd0, 12'd5};
        int lat, bcnt;
        logic da;
        for (int i = 0; i < 3; i++) begin
            run_div(va[i], vb[i], lat, bcnt, da);
            checks++;
            if (bus.quotient !== vq[i] || bus.remainder !== vr[i] || lat !== 24) begin
                failures++;
                $display("FAIL pattern_%0d got q=%h r=%h lat=%0d expected q=%h r=%h lat=24",
                         i, bus.quotient, bus.remainder, lat, vq[i], vr[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat, bcnt;
        logic da;
        run_div(24'h123456, 12'd0, lat, bcnt, da);
        checks++;
        if (bus.quotient !== 24'hFFFFFF || bus.remainder !== 12'h456 || bus.div_by_zero !== 1'b1) begin
            failures++;
            $display("FAIL dbz_result got q=%h r=%h dbz=%b expected FFFFFF 456 1",
                     bus.quotient, bus.remainder, bus.div_by_zero);
        end
        checks++;
        if (lat !== 0 || bcnt !== 0 || da !== 1'b0) begin
            failures++;
            $display("FAIL dbz_timing got lat=%0d busy=%0d done_next=%b expected 0 0 0", lat, bcnt, da);
        end
        run_div(24'd1000, 12'd7, lat, bcnt, da);
        checks++;
        if (bus.div_by_zero !== 1'b0 || bus.quotient !== 24'd142 || bus.remainder !== 12'd6) begin
            failures++;
            $display("FAIL dbz_cleared got dbz=%b q=%0d r=%0d expected 0 142 6",
                     bus.div_by_zero, bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 24'd100;
        bus.divisor  = 12'd3;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.dividend = 24'd50;
        bus.divisor  = 12'd5;
        @(posedge clk);
        #1 bus.start = 1'b0;
        n = 10;
        while (bus.done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n !== 24 || bus.quotient !== 24'd33 || bus.remainder !== 12'd1) begin
            failures++;
            $display("FAIL ignore_start_in_run got n=%0d q=%0d r=%0d expected 24 33 1",
                     n, bus.quotient, bus.remainder);
        end
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.quotient !== 24'd33) begin
            failures++;
            $display("FAIL b2b_accept got done=%b busy=%b q=%0d expected 0 1 33",
                     bus.done, bus.busy, bus.quotient);
        end
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n !== 24 || bus.quotient !== 24'd10 || bus.remainder !== 12'd0) begin
            failures++;
            $display("FAIL b2b_result got n=%0d q=%0d r=%0d expected 24 10 0",
                     n, bus.quotient, bus.remainder);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_abort();
        int lat, bcnt, seen;
        logic da;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 24'd1000;
        bus.divisor  = 12'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (11) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== '0) begin
            failures++;
            $display("FAIL abort_async got busy=%b done=%b dbz=%b q=%h r=%h expected all 0",
                     bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL abort_no_done got %0d done cycles expected 0", seen);
        end
        run_div(24'd1000, 12'd7, lat, bcnt, da);
        checks++;
        if (bus.quotient !== 24'd142 || bus.remainder !== 12'd6 || lat !== 24) begin
            failures++;
            $display("FAIL abort_restart got q=%0d r=%0d lat=%0d expected 142 6 24",
                     bus.quotient, bus.remainder, lat);
        end
    endtask

    task automatic test_random();
        int lat, bcnt, sel;
        logic da;
        logic [23:0] a, eq;
        logic [11:0] b, er;
        for (int i = 0; i < 1500; i++) begin
            sel = int'($urandom_range(0, 7));
            a   = 24'($urandom);
            b   = (sel == 0) ? 12'd0 : (sel == 1) ? 12'd1 : 12'($urandom);
            if (sel == 2) a = 24'($urandom_range(0, 4095));
            run_div(a, b, lat, bcnt, da);
            if (b == 12'd0) begin
                checks++;
                if (bus.quotient !== 24'hFFFFFF || bus.remainder !== a[11:0] ||
                    bus.div_by_zero !== 1'b1 || lat !== 0 || da !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_dbz a=%h got q=%h r=%h dbz=%b lat=%0d expected FFFFFF %h 1 0",
                             a, bus.quotient, bus.remainder, bus.div_by_zero, lat, a[11:0]);
                end
            end else begin
                eq = a / {12'd0, b};
                er = 12'(a % {12'd0, b});
                checks++;
                if (bus.quotient !== eq || bus.remainder !== er || bus.div_by_zero !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_result a=%h b=%h got q=%h r=%h dbz=%b expected q=%h r=%h dbz=0",
                             a, b, bus.quotient, bus.remainder, bus.div_by_zero, eq, er);
                end
                checks++;
                if (48'(bus.quotient) * 48'(b) + 48'(bus.remainder) !== 48'(a) || bus.remainder >= b) begin
                    failures++;
                    $display("FAIL rand_invariant a=%h b=%h got q=%h r=%h", a, b, bus.quotient, bus.remainder);
                end
                checks++;
                if (lat !== 24 || bcnt !== 24 || da !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_timing a=%h b=%h got lat=%0d busy=%0d done_next=%b expected 24 24 0",
                             a, b, lat, bcnt, da);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_div_zero();
        test_back_to_back();
        test_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
